// File: rtl/johnson_ring_counter_param.sv
// Johnson / one-hot ring sequencer with load, self-correction and phase decode.
// One-cycle latency from inputs to q/wrap/err; phase is combinational from q and mode.
module johnson_ring_counter_param #(
  parameter int WIDTH = 5,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [PW-1:0]    ones;
  logic [PW-1:0]    ring_idx;
  logic [PW-1:0]    last_phase;
  logic             cur_legal;
  logic             load_legal;

  // Johnson: at most one transition between neighbouring bits; ring: exactly one bit set.
  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
    int changes;
    int pop;
    changes = 0;
    pop     = 0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + int'(v[i]);
      if (i < WIDTH-1) changes = changes + int'(v[i] ^ v[i+1]);
    end
    return m ? (pop == 1) : (changes <= 1);
  endfunction

  assign cur_legal  = is_legal(q_q, mode);
  assign load_legal = is_legal(load_val, mode);
  assign last_phase = mode ? PW'(WIDTH-1) : PW'(2*WIDTH-1);

  always_comb begin
    ones     = '0;
    ring_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + PW'(q_q[i]);
      if (q_q[i]) ring_idx = PW'(i);
    end
  end

  // Low-anchored ones count up directly; high-anchored ones count down from 2*WIDTH.
  always_comb begin
    phase = '0;
    if (cur_legal) begin
      if (mode)
        phase = ring_idx;
      else if (q_q[0])
        phase = ones;
      else if (ones != '0)
        phase = PW'(2*WIDTH) - ones;
    end
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if (load_legal) begin
        q_d = load_val;
      end else begin
        q_d   = ONE;
        err_d = 1'b1;
      end
    end else if (!cur_legal) begin
      q_d   = ONE;
      err_d = 1'b1;
    end else if (en) begin
      case ({mode, dir})
        2'b00:   q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        2'b01:   q_d = {~q_q[0], q_q[WIDTH-1:1]};
        2'b10:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        default: q_d = {q_q[0], q_q[WIDTH-1:1]};
      endcase
      wrap_d = dir ? (phase == '0) : (phase == last_phase);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= ONE;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_johnson_ring_counter_param.sv
// Directed bench for johnson_ring_counter_param at WIDTH=5.
module tb_johnson_ring_counter_param;

  localparam int WIDTH = 5;
  localparam int PW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en, dir, mode, load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [PW-1:0]    phase;
  logic             wrap, err;

  int total = 0;
  int bad   = 0;

  johnson_ring_counter_param #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .phase    (phase),
    .wrap     (wrap),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply reset with given controls held, release, leave sampling point after release.
  task automatic do_reset(input logic m, input logic d, input logic e);
    @(negedge clk);
    reset = 1'b0; en = e; dir = d; mode = m; load = 1'b0; load_val = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; en = 1'b1; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
    #1;
    total++; if (q !== 5'b00001) begin bad++; $display("FAIL reset_q: got %b want 00001", q); end
    total++; if (wrap !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_flags: got wrap=%b err=%b want 0 0", wrap, err); end
    total++; if (phase !== 4'd1) begin bad++; $display("FAIL reset_phase: got %0d want 1", phase); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_johnson_fwd();
    logic [WIDTH-1:0] exp_q [10] = '{5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b11110,
                                     5'b11100, 5'b11000, 5'b10000, 5'b00000, 5'b00001};
    logic [PW-1:0]    exp_p [10] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
    do_reset(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (q !== exp_q[i] || phase !== exp_p[i] || wrap !== (i == 8)) begin
        bad++;
        $display("FAIL johnson_fwd[%0d]: got q=%b phase=%0d wrap=%b want q=%b phase=%0d wrap=%b",
                 i, q, phase, wrap, exp_q[i], exp_p[i], (i == 8));
      end
    end
  endtask

  task automatic test_johnson_rev();
    logic [WIDTH-1:0] exp_q [3] = '{5'b00000, 5'b10000, 5'b11000};
    logic [PW-1:0]    exp_p [3] = '{4'd0, 4'd9, 4'd8};
    do_reset(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (q !== exp_q[i] || phase !== exp_p[i] || wrap !== (i == 1)) begin
        bad++;
        $display("FAIL johnson_rev[%0d]: got q=%b phase=%0d wrap=%b want q=%b phase=%0d wrap=%b",
                 i, q, phase, wrap, exp_q[i], exp_p[i], (i == 1));
      end
    end
  endtask

  task automatic test_ring();
    logic [WIDTH-1:0] exp_q [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    logic [PW-1:0]    exp_p [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    do_reset(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (q !== exp_q[i] || phase !== exp_p[i] || wrap !== (i == 4)) begin
        bad++;
        $display("FAIL ring_fwd[%0d]: got q=%b phase=%0d wrap=%b want q=%b phase=%0d wrap=%b",
                 i, q, phase, wrap, exp_q[i], exp_p[i], (i == 4));
      end
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (q !== 5'b00001 || wrap !== 1'b0) begin
        bad++; $display("FAIL ring_hold[%0d]: got q=%b wrap=%b want q=00001 wrap=0", i, q, wrap);
      end
    end
    // Reverse from phase 0 wraps to the top bit.
    en = 1'b1; dir = 1'b1;
    tick();
    total++;
    if (q !== 5'b10000 || phase !== 4'd4 || wrap !== 1'b1) begin
      bad++; $display("FAIL ring_rev: got q=%b phase=%0d wrap=%b want q=10000 phase=4 wrap=1", q, phase, wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_load();
    do_reset(1'b0, 1'b0, 1'b0);
    load = 1'b1; load_val = 5'b11100;
    tick();
    total++;
    if (q !== 5'b11100 || phase !== 4'd7 || err !== 1'b0) begin
      bad++; $display("FAIL load_legal: got q=%b phase=%0d err=%b want q=11100 phase=7 err=0", q, phase, err);
    end
    load_val = 5'b01010; en = 1'b1;
    tick();
    total++;
    if (q !== 5'b00001 || err !== 1'b1 || wrap !== 1'b0) begin
      bad++; $display("FAIL load_illegal: got q=%b err=%b wrap=%b want q=00001 err=1 wrap=0", q, err, wrap);
    end
    load = 1'b0; en = 1'b0;
    tick();
    total++;
    if (q !== 5'b00001 || err !== 1'b0) begin
      bad++; $display("FAIL load_err_clear: got q=%b err=%b want q=00001 err=0", q, err);
    end
  endtask

  task automatic test_mode_switch();
    do_reset(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    total++;
    if (q !== 5'b00111) begin bad++; $display("FAIL modesw_pre: got q=%b want 00111", q); end
    en = 1'b0; mode = 1'b1;
    #1;
    total++;
    if (phase !== 4'd0) begin bad++; $display("FAIL illegal_phase: got %0d want 0", phase); end
    tick();
    total++;
    if (q !== 5'b00001 || err !== 1'b1) begin
      bad++; $display("FAIL modesw_correct: got q=%b err=%b want q=00001 err=1", q, err);
    end
    tick();
    total++;
    if (q !== 5'b00001 || err !== 1'b0) begin
      bad++; $display("FAIL modesw_after: got q=%b err=%b want q=00001 err=0", q, err);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (q !== 5'b11110) begin bad++; $display("FAIL areset_pre: got q=%b want 11110", q); end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (q !== 5'b00001 || wrap !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL areset_now: got q=%b wrap=%b err=%b want q=00001 wrap=0 err=0", q, wrap, err);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    total++;
    if (q !== 5'b00011) begin bad++; $display("FAIL areset_resume: got q=%b want 00011", q); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
    test_reset();
    test_johnson_fwd();
    test_johnson_rev();
    test_ring();
    test_load();
    test_mode_switch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
